ifu_prefetch_queue: RTL and testbench
=====================================

# ifu_prefetch_queue

Parametrised instruction-fetch unit for the PDP-8 core: it fetches sequential instruction words from memory ahead of demand and buffers them in a DEPTH-entry prefetch queue. The queue sits between the memory read port and instr_decode, and presents one fetched word plus its address per cycle. The execution unit redirects fetch by loading a new PC and back-pressures the queue with stall. This block supersedes the single-word fetch path with configurable depth and widths, flush-on-redirect and continuous one-word-per-cycle throughput.

## Interface
- ADDR_WIDTH, 12, address width (`ADDR_WIDTH in pdp8_pkg)
- DATA_WIDTH, 12, instruction word width (`DATA_WIDTH in pdp8_pkg)
- DEPTH, 4, queue entries; power of two, >= 2
- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  reset, asynchronous assert, active-low
- load_pc  in  1  redirect strobe from execution unit
- PC_value  in  ADDR_WIDTH  redirect target, sampled when load_pc=1
- stall  in  1  decode not accepting; holds the queue head
- ifu_rd_req  out  1  memory read request (registered)
- ifu_rd_addr  out  ADDR_WIDTH  read address (registered)
- ifu_rd_data  in  DATA_WIDTH  read data, valid exactly one cycle after ifu_rd_req
- instr_valid  out  1  queue head valid
- instr_data  out  DATA_WIDTH  head instruction word
- instr_addr  out  ADDR_WIDTH  address of head word
- q_count  out  $clog2(DEPTH+1)  valid queue entries

## Operation
- FSM states: IDLE (after reset, no fetch) and FETCH. IDLE -> FETCH on load_pc. FETCH -> FETCH on load_pc (redirect). Only reset returns the FSM to IDLE.
- Fetch pointer fp: set to PC_value on load_pc. Increments by 1 per issued request, modulo 2^ADDR_WIDTH (7777 -> 0000).
- Request issue in FETCH: ifu_rd_req=1 with ifu_rd_addr=fp only when q_count + outstanding < DEPTH.
  - outstanding = requests issued whose data has not yet been written (0..2).
  - This rule guarantees no queue overflow.
- Return: data arriving the cycle after a live request is written at the tail with its address.
- Pop: head is removed at the edge when instr_valid=1 and stall=0.
- Simultaneous write and pop leave q_count unchanged.
- Redirect (load_pc=1):
  - Queue is flushed at that edge: q_count=0, instr_valid=0.
  - Any response returning in the following cycle is discarded (kill flag).
  - A pop in the same cycle is ignored; load_pc wins.
- stall with instr_valid=1: instr_data and instr_addr are held stable. Prefetch continues until the queue is full.
- Reset mid-operation: all state is cleared asynchronously, FSM goes to IDLE, and data for in-flight requests is discarded.
- Reset values: ifu_rd_req=0, ifu_rd_addr=0, instr_valid=0, instr_data=0, instr_addr=0, q_count=0.

## Timing
- load_pc in cycle N -> first ifu_rd_req in cycle N+1 with addr=PC_value -> data in N+2 -> instr_valid in N+3 (N+2 with bypass).
- Steady state with stall=0: one request per cycle and one instr_valid word per cycle.
- Full queue (q_count=DEPTH): ifu_rd_req=0.
- When the head is popped from a full queue at edge E, a new request is asserted in the cycle after E.
- ifu_rd_req and ifu_rd_addr never change combinationally from inputs.

## Configuration
- IFU_BYPASS_EN defined: when the queue is empty and valid data returns, instr_valid, instr_data and instr_addr are driven combinationally from ifu_rd_data in that same cycle.
  - If stall=0, the word is consumed without being written.
  - If stall=1, the word is written into the queue.
  - Redirect-to-first-valid latency is 2 cycles.
- IFU_BYPASS_EN undefined: all outputs come from queue registers only; latency is 3 cycles.

## Test plan
- Reset, load_pc with PC_value=0200, stall=0, memory returns word = address: requests 0200,0201,0202... on consecutive cycles. instr_valid first in N+3 with instr_addr=0200, instr_data=0200, then one word per cycle.
- DEPTH=4, stall=1 after load_pc 0300: exactly 4 requests (0300..0303), q_count reaches 4, ifu_rd_req stays 0. Release stall for 1 cycle: 0300 is popped and a request for 0304 follows on the next cycle.
- Redirect mid-flight: load_pc 0400 while 0205 is outstanding. The 0205 data is dropped, q_count=0 the cycle after load_pc, and the next instr_addr is 0400.
- Wrap: load_pc 7776 -> ifu_rd_addr sequence 7776, 7777, 0000, 0001, and instr_addr follows the same order.
- Assert reset_n=0 asynchronously with 3 entries queued and a request outstanding: all outputs go to 0 immediately. After release, no requests are issued until load_pc.
- Compile with and without IFU_BYPASS_EN: load_pc at N gives first instr_valid at N+2 and N+3 respectively, with identical instruction order.

Source files
------------

// File: rtl/ifu_prefetch_queue.sv
// PDP-8 instruction prefetch queue: sequential fetch ahead of decode, flush on redirect.
// Define IFU_BYPASS_EN to forward a returning word straight to the head when the queue is empty.
module ifu_prefetch_queue #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         load_pc,
  input  logic [ADDR_WIDTH-1:0]        PC_value,
  input  logic                         stall,
  output logic                         ifu_rd_req,
  output logic [ADDR_WIDTH-1:0]        ifu_rd_addr,
  input  logic [DATA_WIDTH-1:0]        ifu_rd_data,
  output logic                         instr_valid,
  output logic [DATA_WIDTH-1:0]        instr_data,
  output logic [ADDR_WIDTH-1:0]        instr_addr,
  output logic [$clog2(DEPTH+1)-1:0]   q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   fp_reg, fp_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [ADDR_WIDTH-1:0]   pend_addr_reg;
  logic                    req_reg, req_next;
  logic                    pend_reg, pend_next;
  logic [CW-1:0]           count_reg, count_next;
  logic [PW-1:0]           rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]           wr_ptr_reg, wr_ptr_next;
  logic [CW:0]             occupancy;
  logic                    q_write, q_pop, bypass;
  logic [DEPTH-1:0]        entry_we;

  logic [DATA_WIDTH-1:0]   q_data [DEPTH];
  logic [ADDR_WIDTH-1:0]   q_addr [DEPTH];

  always_comb begin
    state_next  = state_reg;
    fp_next     = fp_reg;
    addr_next   = addr_reg;
    req_next    = 1'b0;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    bypass      = 1'b0;
    // A redirect kills whatever response lands in the next cycle.
    pend_next   = req_reg && !load_pc;
`ifdef IFU_BYPASS_EN
    bypass      = pend_reg && (count_reg == '0) && !stall && !load_pc;
`endif
    q_pop   = (count_reg != '0) && !stall && !load_pc;
    q_write = pend_reg && !load_pc && !bypass;

    if (load_pc) begin
      count_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
    end else begin
      if (q_write) wr_ptr_next = wr_ptr_reg + PW'(1);
      if (q_pop)   rd_ptr_next = rd_ptr_reg + PW'(1);
      case ({q_write, q_pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end

    // Entries held plus data still in flight; a new request must fit behind both.
    occupancy = {1'b0, count_next} + (CW+1)'(pend_next);

    case (state_reg)
      IDLE:    if (load_pc) state_next = FETCH;
      FETCH:   state_next = FETCH;
      default: state_next = IDLE;
    endcase

    if (load_pc) begin
      req_next  = 1'b1;
      addr_next = PC_value;
      fp_next   = PC_value + ADDR_WIDTH'(1);
    end else if (state_reg == FETCH && occupancy < DEPTH_C) begin
      req_next  = 1'b1;
      addr_next = fp_reg;
      fp_next   = fp_reg + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      fp_reg        <= '0;
      addr_reg      <= '0;
      req_reg       <= 1'b0;
      pend_reg      <= 1'b0;
      pend_addr_reg <= '0;
      count_reg     <= '0;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      fp_reg        <= fp_next;
      addr_reg      <= addr_next;
      req_reg       <= req_next;
      pend_reg      <= pend_next;
      pend_addr_reg <= addr_reg;
      count_reg     <= count_next;
      rd_ptr_reg    <= rd_ptr_next;
      wr_ptr_reg    <= wr_ptr_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry_we
      assign entry_we[gi] = q_write && (wr_ptr_reg == PW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_data[i] <= '0;
        q_addr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entry_we[i]) begin
          q_data[i] <= ifu_rd_data;
          q_addr[i] <= pend_addr_reg;
        end
      end
    end
  end

  // Head outputs read zero whenever nothing valid is presented.
  always_comb begin
    instr_valid = (count_reg != '0);
    instr_data  = instr_valid ? q_data[rd_ptr_reg] : '0;
    instr_addr  = instr_valid ? q_addr[rd_ptr_reg] : '0;
`ifdef IFU_BYPASS_EN
    if (pend_reg && (count_reg == '0)) begin
      instr_valid = 1'b1;
      instr_data  = ifu_rd_data;
      instr_addr  = pend_addr_reg;
    end
`endif
  end

  assign ifu_rd_req  = req_reg;
  assign ifu_rd_addr = addr_reg;
  assign q_count     = count_reg;

endmodule

// File: tb/tb_ifu_prefetch_queue.sv
// Scoreboard bench for ifu_prefetch_queue: memory returns addr^mem_mask one cycle after each request.
module tb_ifu_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_pc;
  logic [11:0] PC_value;
  logic        stall;
  logic        ifu_rd_req;
  logic [11:0] ifu_rd_addr;
  logic [11:0] ifu_rd_data;
  logic        instr_valid;
  logic [11:0] instr_data;
  logic [11:0] instr_addr;
  logic [2:0]  q_count;

  logic [11:0] mem_mask = 12'o0000;
  logic [11:0] exp_req_q[$];
  logic [11:0] exp_ins_q[$];
  logic [11:0] mon_a;
  int n_checks = 0;
  int n_pass   = 0;
  int req_cnt  = 0;
  int cons_cnt = 0;

  ifu_prefetch_queue #(.ADDR_WIDTH(12), .DATA_WIDTH(12), .DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .load_pc(load_pc), .PC_value(PC_value),
    .stall(stall), .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr),
    .ifu_rd_data(ifu_rd_data), .instr_valid(instr_valid), .instr_data(instr_data),
    .instr_addr(instr_addr), .q_count(q_count)
  );

  always #5 clk = ~clk;

  // Memory read port: one-cycle latency.
  always @(posedge clk) ifu_rd_data <= ifu_rd_addr ^ mem_mask;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0o expected %0o", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [11:0] pc);
    step();
    load_pc  = 1'b1;
    PC_value = pc;
    step();
    load_pc  = 1'b0;
  endtask

  // Compare every issued request and every consumed word against the expected stream.
  always @(negedge clk) begin
    if (reset_n) begin
      if (ifu_rd_req) begin
        req_cnt++;
        if (exp_req_q.size() == 0) check("req_unexpected", 32'd1, 32'd0);
        else begin
          mon_a = exp_req_q.pop_front();
          check("req_addr", ifu_rd_addr, mon_a);
        end
      end
      if (instr_valid && !stall && !load_pc) begin
        cons_cnt++;
        if (exp_ins_q.size() == 0) check("instr_unexpected", 32'd1, 32'd0);
        else begin
          mon_a = exp_ins_q.pop_front();
          $display("instr addr=%04o data=%04o (exp addr=%04o)", instr_addr, instr_data, mon_a);
          check("instr_addr", instr_addr, mon_a);
          check("instr_data", instr_data, mon_a ^ mem_mask);
        end
      end
      if (load_pc) begin
        exp_req_q.delete();
        exp_ins_q.delete();
        for (int i = 0; i < 48; i++) begin
          exp_req_q.push_back(PC_value + 12'(i));
          exp_ins_q.push_back(PC_value + 12'(i));
        end
      end
    end
  end

  initial begin
    int lat, nv, nr;
    bit found;
    int exp_lat;
`ifdef IFU_BYPASS_EN
    exp_lat = 2;
`else
    exp_lat = 3;
`endif
    reset_n = 1'b0; load_pc = 1'b0; PC_value = '0; stall = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req", ifu_rd_req, 0);
    check("rst_addr", ifu_rd_addr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_data", instr_data, 0);
    check("rst_iaddr", instr_addr, 0);
    check("rst_count", q_count, 0);
    #2 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_req", ifu_rd_req, 0);

    // Streaming from 0200, latency and throughput
    do_load(12'o0200);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (instr_valid) begin lat = k; break; end
    end
    check("first_latency", lat, exp_lat);
    check("first_addr", instr_addr, 12'o0200);
    nv = 0; nr = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      nv += int'(instr_valid);
      nr += int'(ifu_rd_req);
    end
    check("thru_valid", nv, 8);
    check("thru_req", nr, 8);

    // Stall fills the queue to DEPTH and stops requests
    step(); stall = 1'b1;
    do_load(12'o0300);
    req_cnt = 0;
    repeat (10) @(negedge clk);
    check("stall_req_cnt", req_cnt, 4);
    check("stall_count", q_count, 4);
    check("stall_no_req", ifu_rd_req, 0);
    check("stall_head_addr", instr_addr, 12'o0300);
    check("stall_head_data", instr_data, 12'o0300);
    @(negedge clk);
    check("stall_hold_addr", instr_addr, 12'o0300);
    step(); stall = 1'b0;
    step(); stall = 1'b1;
    @(negedge clk);
    check("refill_req", ifu_rd_req, 1);
    check("refill_addr", ifu_rd_addr, 12'o0304);
    check("refill_count", q_count, 3);

    // Redirect while 0205 is in flight
    step(); stall = 1'b0;
    do_load(12'o0200);
    found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ifu_rd_req && ifu_rd_addr == 12'o0205) begin found = 1'b1; break; end
    end
    check("found_0205", found, 1);
    do_load(12'o0400);
    @(negedge clk);
    check("redir_count", q_count, 0);
    check("redir_valid", instr_valid, 0);
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (instr_valid) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("redir_seen", found, 1);
    check("redir_addr", instr_addr, 12'o0400);

    // Address wrap 7777 -> 0000
    do_load(12'o7776);
    cons_cnt = 0;
    repeat (8) @(negedge clk);
    check("wrap_flow", cons_cnt >= 4, 1);

    // Asynchronous reset with 3 entries queued and a request in flight
    step(); stall = 1'b1;
    do_load(12'o0500);
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (q_count == 3) begin found = 1'b1; break; end
    end
    check("pre_rst_count3", found, 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_req", ifu_rd_req, 0);
    check("arst_addr", ifu_rd_addr, 0);
    check("arst_valid", instr_valid, 0);
    check("arst_data", instr_data, 0);
    check("arst_iaddr", instr_addr, 0);
    check("arst_count", q_count, 0);
    exp_req_q.delete();
    exp_ins_q.delete();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    stall = 1'b0;
    mem_mask = 12'o5252;
    req_cnt = 0;
    repeat (5) @(negedge clk);
    check("post_rst_no_req", req_cnt, 0);
    check("post_rst_valid", instr_valid, 0);
    do_load(12'o0600);
    cons_cnt = 0;
    repeat (12) @(negedge clk);
    check("post_rst_flow", cons_cnt >= 8, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
